hit_judge: RTL

- Upstream judgement stage for the BCD score accumulator.
- Compares the player's click position against the current beat target on the circular track. Classifies each hit as perfect, great, good or miss, and emits the signed deviation.
- Issues a one-cycle cal pulse with result/dev, spaced so the downstream BCD-adder accumulator is never re-triggered while busy.
- Also exports the last click and target angles for the detailed-judgement display.

---
 rtl/hit_judge_pkg.sv | 26 ++
 rtl/hit_judge_if.sv | 25 ++
 rtl/judge_out_fifo.sv | 77 +++++++
 rtl/hit_judge.sv | 101 ++++++++++
 4 files changed

// File: rtl/hit_judge_pkg.sv
// Shared types for the hit judgement stage: grade codes, FSM states and the
// result record handed from the classifier to the output scheduler.
package judge_pkg;

    localparam int ANG_W = 16;

    typedef enum logic [1:0] {
        GR_PERFECT = 2'd0,
        GR_GREAT   = 2'd1,
        GR_GOOD    = 2'd2,
        GR_MISS    = 2'd3
    } grade_e;

    typedef enum logic {IDLE, ARMED} state_e;

    typedef struct packed {
        logic [2:0]             result;
        logic signed [ANG_W-1:0] dev;
    } res_t;

    // Magnitude of a signed deviation; -2^15 wraps but is far outside any window.
    function automatic logic [ANG_W-1:0] abs_dev(input logic signed [ANG_W-1:0] d);
        return d[ANG_W-1] ? ANG_W'(-d) : ANG_W'(d);
    endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Game-side bus of the hit judge: click/target inputs and the scored result outputs.
interface hit_judge_if;
    logic                                en;
    logic        [judge_pkg::ANG_W-1:0]  angle;
    logic        [judge_pkg::ANG_W-1:0]  target;
    logic                                target_valid;
    logic                                click;
    logic                                cal;
    logic        [2:0]                   result;
    logic signed [judge_pkg::ANG_W-1:0]  dev;
    logic                                armed;
    logic        [judge_pkg::ANG_W-1:0]  last_click;
    logic        [judge_pkg::ANG_W-1:0]  last_target;
    logic                                overflow;

    modport master (
        output en, angle, target, target_valid, click,
        input  cal, result, dev, armed, last_click, last_target, overflow
    );

    modport slave (
        input  en, angle, target, target_valid, click,
        output cal, result, dev, armed, last_click, last_target, overflow
    );
endinterface

// File: rtl/judge_out_fifo.sv
// One-entry pending buffer plus gap counter that paces cal strobes so the
// downstream accumulator never sees a new strobe while it is still adding.
module judge_out_fifo
    import judge_pkg::*;
#(
    parameter int GAP = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  res_t push_data_i,
    output logic valid_o,
    output res_t data_o,
    output logic overflow_o
);

    localparam int CW = $clog2(GAP + 1);

    logic [CW-1:0] gap_q, gap_d;
    logic          pend_vld_q, pend_vld_d;
    res_t          pend_q, pend_d;
    logic          valid_q, valid_d;
    res_t          data_q, data_d;
    logic          ovf_q, ovf_d;

    always_comb begin
        gap_d      = (gap_q != '0) ? gap_q - CW'(1) : gap_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        ovf_d      = ovf_q;

        if (gap_q == '0 && pend_vld_q) begin
            // Pending drains first; a same-cycle push takes the freed slot.
            valid_d    = 1'b1;
            data_d     = pend_q;
            pend_vld_d = push_i;
            if (push_i) pend_d = push_data_i;
        end else if (gap_q == '0 && push_i) begin
            valid_d = 1'b1;
            data_d  = push_data_i;
        end else if (push_i) begin
            if (pend_vld_q) begin
                ovf_d = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_d     = push_data_i;
            end
        end

        if (valid_d) gap_d = CW'(GAP - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            gap_q      <= gap_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/hit_judge.sv
// Classifies clicks against the current beat target on a circular track and
// hands graded results with signed deviation to the paced output scheduler.
module hit_judge
    import judge_pkg::*;
#(
    parameter int PERFECT_WIN = 2,
    parameter int GREAT_WIN   = 8,
    parameter int GOOD_WIN    = 24,
    parameter int GAP         = 16
) (
    input  logic        clk,
    input  logic        rst,
    hit_judge_if.slave  bus
);

    state_e                  state_q, state_d;
    logic [ANG_W-1:0]        tgt_q, tgt_d;
    logic [ANG_W-1:0]        last_click_q, last_click_d;
    logic [ANG_W-1:0]        last_target_q, last_target_d;

    logic signed [ANG_W-1:0] d;
    logic [ANG_W-1:0]        mag;
    logic                    in_win, expired, late;
    logic                    judge, expire;
    logic                    push;
    res_t                    pdata, out_data;
    logic [1:0]              grade;

    // Modular subtraction reinterpreted as signed handles the wrap through 0.
    assign d       = signed'(bus.angle - tgt_q);
    assign mag     = abs_dev(d);
    assign in_win  = (mag <= ANG_W'(GOOD_WIN));
    assign late    = !d[ANG_W-1] && (d != '0);
    assign expired = !d[ANG_W-1] && !in_win;

    assign judge  = (state_q == ARMED) && bus.en && bus.click && in_win;
    // A replaced target counts as missed even while the game is paused.
    assign expire = (state_q == ARMED) && !judge && ((bus.en && expired) || bus.target_valid);

    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        last_click_d  = last_click_q;
        last_target_d = last_target_q;
        push          = 1'b0;
        pdata.result  = '0;
        pdata.dev     = d;
        grade         = GR_GOOD;

        if (mag <= ANG_W'(PERFECT_WIN))    grade = GR_PERFECT;
        else if (mag <= ANG_W'(GREAT_WIN)) grade = GR_GREAT;

        if (judge) begin
            push          = 1'b1;
            pdata.result  = {late, grade};
            last_click_d  = bus.angle;
            last_target_d = tgt_q;
            state_d       = IDLE;
        end else if (expire) begin
            push          = 1'b1;
            pdata.result  = {1'b1, GR_MISS};
            state_d       = IDLE;
        end

        if (bus.target_valid) begin
            tgt_d   = bus.target;
            state_d = ARMED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tgt_q         <= '0;
            last_click_q  <= '0;
            last_target_q <= '0;
        end else begin
            state_q       <= state_d;
            tgt_q         <= tgt_d;
            last_click_q  <= last_click_d;
            last_target_q <= last_target_d;
        end
    end

    judge_out_fifo #(.GAP(GAP)) u_out (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (pdata),
        .valid_o     (bus.cal),
        .data_o      (out_data),
        .overflow_o  (bus.overflow)
    );

    assign bus.result      = out_data.result;
    assign bus.dev         = out_data.dev;
    assign bus.armed       = (state_q == ARMED);
    assign bus.last_click  = last_click_q;
    assign bus.last_target = last_target_q;

endmodule
